// File: rtl/wb_port_arbiter.sv
// Writeback arbiter merging the in-order pipe with a 2-entry long-latency result FIFO; optional WB_ARB_PERF_EN adds conflict_cnt.
// Latency: the winner's write appears on wr_reg/wregno/regval one clock after it wins arbitration.
// Backpressure: ll_ready drops when the FIFO holds two entries; pipe_stall is raised for the one forced LL cycle after a starvation run.
module wb_port_arbiter #(
    parameter int DBITS        = 32,
    parameter int REGNOBITS    = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pipe_valid,
    input  logic                 pipe_wr_reg,
    input  logic [REGNOBITS-1:0] pipe_wregno,
    input  logic [DBITS-1:0]     pipe_regval,
    output logic                 pipe_stall,
    input  logic                 ll_valid,
    input  logic [REGNOBITS-1:0] ll_wregno,
    input  logic [DBITS-1:0]     ll_regval,
    output logic                 ll_ready,
    output logic                 wr_reg,
    output logic [REGNOBITS-1:0] wregno,
`ifdef WB_ARB_PERF_EN
    output logic [DBITS-1:0]     regval,
    output logic [31:0]          conflict_cnt
`else
    output logic [DBITS-1:0]     regval
`endif
);

    typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t               state;
    logic [3:0]           starve_cnt;
    logic [3:0]           starve_nxt;
    logic [1:0]           count;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [REGNOBITS-1:0] fifo_regno [2];
    logic [DBITS-1:0]     fifo_data  [2];

    logic                 pipe_req;
    logic                 fifo_ne;
    logic                 push;
    logic                 pipe_win;
    logic                 ll_win;
    logic [REGNOBITS-1:0] win_regno;
    logic [DBITS-1:0]     win_data;

    always_comb begin
        pipe_req   = pipe_valid & pipe_wr_reg;
        fifo_ne    = (count != 2'd0);
        // Readiness comes from the registered count only; a same-cycle pop does not free a slot.
        ll_ready   = ~reset & (count < 2'd2);
        push       = ll_valid & ll_ready;
        pipe_win   = (state == ST_NORMAL) & pipe_req;
        ll_win     = fifo_ne & ((state == ST_FORCE) | ~pipe_req);
        pipe_stall = (state == ST_FORCE) & pipe_req;
        starve_nxt = starve_cnt + 4'd1;
        win_regno  = ll_win ? fifo_regno[rd_ptr] : pipe_wregno;
        win_data   = ll_win ? fifo_data[rd_ptr]  : pipe_regval;
    end

    // FIFO storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_regno[wr_ptr] <= ll_wregno;
            fifo_data[wr_ptr]  <= ll_regval;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_NORMAL;
            starve_cnt <= 4'd0;
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_reg     <= 1'b0;
            wregno     <= '0;
            regval     <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (ll_win) rd_ptr <= ~rd_ptr;
            case ({push, ll_win})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            // A winner targeting x0 is consumed without a register-file write.
            wr_reg <= (pipe_win | ll_win) & (win_regno != '0);
            if (pipe_win | ll_win) begin
                wregno <= win_regno;
                regval <= win_data;
            end

            case (state)
                ST_NORMAL: begin
                    if (ll_win) begin
                        starve_cnt <= 4'd0;
                    end else if (pipe_win && fifo_ne) begin
                        starve_cnt <= starve_nxt;
                        if (starve_nxt == LIMIT) state <= ST_FORCE;
                    end
                end
                default: begin
                    state      <= ST_NORMAL;
                    starve_cnt <= 4'd0;
                end
            endcase
        end
    end

`ifdef WB_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= 32'd0;
        end else if (pipe_req && fifo_ne && (conflict_cnt != 32'hFFFF_FFFF)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: pipe/LL arbitration, starvation forcing, FIFO full, x0 and async reset.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_valid;
    logic        pipe_wr_reg;
    logic [4:0]  pipe_wregno;
    logic [31:0] pipe_regval;
    logic        pipe_stall;
    logic        ll_valid;
    logic [4:0]  ll_wregno;
    logic [31:0] ll_regval;
    logic        ll_ready;
    logic        wr_reg;
    logic [4:0]  wregno;
    logic [31:0] regval;
`ifdef WB_ARB_PERF_EN
    logic [31:0] conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    wb_port_arbiter #(.DBITS(32), .REGNOBITS(5), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_valid  (pipe_valid),
        .pipe_wr_reg (pipe_wr_reg),
        .pipe_wregno (pipe_wregno),
        .pipe_regval (pipe_regval),
        .pipe_stall  (pipe_stall),
        .ll_valid    (ll_valid),
        .ll_wregno   (ll_wregno),
        .ll_regval   (ll_regval),
        .ll_ready    (ll_ready),
        .wr_reg      (wr_reg),
        .wregno      (wregno),
`ifdef WB_ARB_PERF_EN
        .regval      (regval),
        .conflict_cnt(conflict_cnt)
`else
        .regval      (regval)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic v, input logic wr, input logic [4:0] rn, input logic [31:0] d);
        pipe_valid  = v;
        pipe_wr_reg = wr;
        pipe_wregno = rn;
        pipe_regval = d;
    endtask

    task automatic set_ll(input logic v, input logic [4:0] rn, input logic [31:0] d);
        ll_valid  = v;
        ll_wregno = rn;
        ll_regval = d;
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] rn, input logic [31:0] d);
        check({tag, "_wr"}, 32'(wr_reg), 32'd1);
        check({tag, "_no"}, 32'(wregno), 32'(rn));
        check({tag, "_val"}, regval, d);
    endtask

    initial begin
        reset = 1'b1;
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        set_ll(1'b0, 5'd0, 32'd0);
        step;
        step;
        check("rst_wr_reg", 32'(wr_reg), 32'd0);
        check("rst_wregno", 32'(wregno), 32'd0);
        check("rst_regval", regval, 32'd0);
        check("rst_ll_ready", 32'(ll_ready), 32'd0);
        check("rst_stall", 32'(pipe_stall), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ll_ready", 32'(ll_ready), 32'd1);

        // Pipe only
        set_pipe(1'b1, 1'b1, 5'd5, 32'h1234);
        #1 check("pipe_stall_normal", 32'(pipe_stall), 32'd0);
        step;
        expect_wr("pipe_x5", 5'd5, 32'h1234);
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        step;
        check("idle_wr_reg", 32'(wr_reg), 32'd0);
        check("idle_hold_no", 32'(wregno), 32'd5);

        // LL only: push, then pop one cycle later
        set_ll(1'b1, 5'd7, 32'hBEEF);
        #1 check("ll_ready_empty", 32'(ll_ready), 32'd1);
        step;
        set_ll(1'b0, 5'd0, 32'd0);
        check("ll_push_no_wr", 32'(wr_reg), 32'd0);
        check("ll_ready_one", 32'(ll_ready), 32'd1);
        step;
        expect_wr("ll_x7", 5'd7, 32'hBEEF);

        // Starvation: queue x9 behind a busy pipe
        set_pipe(1'b1, 1'b1, 5'd1, 32'h11);
        set_ll(1'b1, 5'd9, 32'hAA);
        step;
        set_ll(1'b0, 5'd0, 32'd0);
        expect_wr("starve_pre", 5'd1, 32'h11);
        for (int k = 1; k <= 4; k++) begin
            set_pipe(1'b1, 1'b1, 5'(10 + k), 32'(k));
            #1 check("starve_no_stall", 32'(pipe_stall), 32'd0);
            step;
            expect_wr("starve_pipe", 5'(10 + k), 32'(k));
        end
        set_pipe(1'b1, 1'b1, 5'd15, 32'h15);
        #1 check("force_stall", 32'(pipe_stall), 32'd1);
        step;
        expect_wr("force_ll_x9", 5'd9, 32'hAA);
        check("resume_no_stall", 32'(pipe_stall), 32'd0);
        step;
        expect_wr("resume_pipe", 5'd15, 32'h15);

        // Full FIFO while pipe busy
        set_pipe(1'b1, 1'b1, 5'd2, 32'h22);
        set_ll(1'b1, 5'd20, 32'h100);
        step;
        set_ll(1'b1, 5'd21, 32'h101);
        step;
        set_ll(1'b1, 5'd22, 32'h102);
        check("full_ll_ready", 32'(ll_ready), 32'd0);
        step;
        check("full_hold_ready", 32'(ll_ready), 32'd0);
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        step;
        expect_wr("full_pop20", 5'd20, 32'h100);
        check("full_ready_after_pop", 32'(ll_ready), 32'd1);
        step;
        set_ll(1'b0, 5'd0, 32'd0);
        expect_wr("full_pop21", 5'd21, 32'h101);
        step;
        expect_wr("full_pop22", 5'd22, 32'h102);
        step;
        check("full_drained", 32'(wr_reg), 32'd0);

        // x0 writes are consumed silently
        set_pipe(1'b1, 1'b1, 5'd0, 32'h55);
        step;
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        check("pipe_x0_no_wr", 32'(wr_reg), 32'd0);
        set_ll(1'b1, 5'd0, 32'h66);
        step;
        set_ll(1'b1, 5'd3, 32'h77);
        step;
        set_ll(1'b0, 5'd0, 32'd0);
        check("ll_x0_no_wr", 32'(wr_reg), 32'd0);
        step;
        expect_wr("ll_after_x0", 5'd3, 32'h77);

        // Reach FORCE with a full FIFO, then reset asynchronously
        set_pipe(1'b1, 1'b1, 5'd2, 32'h222);
        set_ll(1'b1, 5'd24, 32'h240);
        step;
        set_ll(1'b1, 5'd25, 32'h250);
        step;
        set_ll(1'b0, 5'd0, 32'd0);
        step;
        step;
        step;
        check("pre_rst_force", 32'(pipe_stall), 32'd1);
        check("pre_rst_full", 32'(ll_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_wr_reg", 32'(wr_reg), 32'd0);
        check("arst_wregno", 32'(wregno), 32'd0);
        check("arst_regval", regval, 32'd0);
        check("arst_ll_ready", 32'(ll_ready), 32'd0);
        check("arst_stall", 32'(pipe_stall), 32'd0);
        step;
        reset = 1'b0;
        #1;
        check("rel_ll_ready", 32'(ll_ready), 32'd1);
        check("rel_stall", 32'(pipe_stall), 32'd0);
`ifdef WB_ARB_PERF_EN
        check("rel_conflict", conflict_cnt, 32'd0);
`endif
        set_pipe(1'b1, 1'b1, 5'd4, 32'h44);
        step;
        expect_wr("rel_pipe", 5'd4, 32'h44);
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        step;
        check("rel_fifo_empty", 32'(wr_reg), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
